ahb_arbiter: RTL and testbench
==============================

AHB_ARBITER -- requirements
Module: ahb_arbiter

Interface
REQ-001 Parameter NUM_M, default 3: number of AHB masters; legal range 2..4.
REQ-002 Parameter DEFAULT_M, default 0: master parked on when no master requests.
REQ-003 Parameter MAX_HOLD, default 8: accepted transfers after which an owner may be pre-empted.
REQ-004 hclk  in  1: bus clock; all state changes on its rising edge.
REQ-005 hreset  in  1: reset, asynchronous, active-high.
REQ-006 hbusreq  in  NUM_M: per-master bus request; a master holds it high until it presents its final beat's address.
REQ-007 hlock  in  NUM_M: per-master lock request; meaningful only together with hbusreq.
REQ-008 htrans  in  2: muxed address-phase transfer type of the current owner (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
REQ-009 hready  in  1: bus ready, taken from the slave-select decoder's hready_out.
REQ-010 hgrant  out  NUM_M: one-hot grant, registered.
REQ-011 hmaster  out  2: binary index of the granted master, used as the address-phase mux select.
REQ-012 hmaster_d  out  2: data-phase owner index, used as the write-data mux select.
REQ-013 hmastlock  out  1: the current owner's transfers are locked.

Function
REQ-014 hgrant SHALL be one-hot at all times, and hmaster SHALL equal the encoded hgrant.
REQ-015 Owner: the master whose hgrant bit is set.
  - locked = hlock[owner] & hbusreq[owner].
REQ-016 hold_cnt SHALL count accepted transfers, i.e. cycles with hready=1 and htrans[1]=1, while owned.
  - Saturates at MAX_HOLD.
  - Clears on every grant change.
REQ-017 Arbitration point arb_en SHALL be: hready=1 & ~locked & htrans!=BUSY & (hbusreq[owner]=0 | (hold_cnt>=MAX_HOLD & htrans=IDLE)).
REQ-018 On arb_en, the next owner SHALL be the first requesting master, searching round-robin from owner+1 (mod NUM_M).
  - The current owner is considered last.
REQ-019 On arb_en with no hbusreq bit set, hgrant SHALL move to (or stay on) DEFAULT_M.
REQ-020 Without arb_en, hgrant SHALL hold its value, whatever hbusreq does.
REQ-021 The grant change SHALL take effect at the clock edge ending the arb_en cycle (one-cycle latency).
REQ-022 hmaster_d SHALL load hmaster on every edge where hready=1, and hold it while hready=0.
REQ-023 hmastlock SHALL be registered as the value of locked for the owner granted in the next cycle.
  - It SHALL deassert on the edge after the owner drops hlock or hbusreq.
REQ-024 Pre-emption by hold_cnt SHALL occur only while htrans=IDLE; an owner's SEQ/NONSEQ burst is never cut.
REQ-025 Simultaneous requests SHALL be resolved solely by the round-robin order of REQ-018.
REQ-026 While hready=0, no grant change, no hold_cnt increment, and no hmaster_d update SHALL occur.
REQ-027 A request from a master index >= NUM_M cannot exist; hbusreq and hlock bits beyond NUM_M are not present.

Reset
REQ-028 While hreset=1, and immediately on its assertion, the block SHALL force:
  - hgrant = one-hot(DEFAULT_M)
  - hmaster = DEFAULT_M
  - hmaster_d = DEFAULT_M
  - hmastlock = 0
  - hold_cnt = 0
  - round-robin pointer = DEFAULT_M
REQ-029 A reset asserted mid-burst or mid-lock SHALL abandon that ownership without waiting for hready.
REQ-030 Arbitration SHALL resume on the first rising edge after hreset deasserts.

Verification
REQ-031 Park: reset, then hbusreq=000 for 5 cycles with hready=1 -> hgrant=001, hmaster=0, hmaster_d=0 throughout.
REQ-032 Round-robin: owner 0, hbusreq=111, each master drops its request after one NONSEQ -> grants go 0->1->2->0, one cycle after each drop.
REQ-033 Wait state: owner 1 drops hbusreq while hready=0 for 3 cycles, master 2 requesting -> hgrant stays 010 until the hready=1 edge, then becomes 100; hmaster_d follows one hready edge later.
REQ-034 Lock: master 2 holds hlock=1, hbusreq=1 with htrans=IDLE for 20 cycles, others requesting -> hgrant=100 and hmastlock=1 throughout; after hlock drops and hbusreq drops, the grant moves next cycle and hmastlock falls.
REQ-035 Pre-emption: master 0 keeps hbusreq=1 and does 8 SEQ/NONSEQ transfers then IDLE, master 1 requesting -> grant moves to 010 on the IDLE cycle, not earlier.
REQ-036 Reset mid-burst: owner 1 in SEQ with hready=0, assert hreset -> outputs take the REQ-028 values immediately, without a clock edge.

Source files
------------

// File: rtl/ahb_arbiter_if.sv
// Arbiter-side AHB signals: master requests and transfer status in, grant and owner indices out.
interface ahb_arbiter_if #(
  parameter int unsigned NUM_M = 3
) ();
  logic [NUM_M-1:0] hbusreq;
  logic [NUM_M-1:0] hlock;
  logic [1:0]       htrans;
  logic             hready;
  logic [NUM_M-1:0] hgrant;
  logic [1:0]       hmaster;
  logic [1:0]       hmaster_d;
  logic             hmastlock;

  modport slave (
    input  hbusreq, hlock, htrans, hready,
    output hgrant, hmaster, hmaster_d, hmastlock
  );

  modport master (
    output hbusreq, hlock, htrans, hready,
    input  hgrant, hmaster, hmaster_d, hmastlock
  );
endinterface

// File: rtl/ahb_arbiter.sv
// Round-robin AHB bus arbiter with default-master parking, bus locking and
// hold-count pre-emption that only takes effect on IDLE cycles.
module ahb_arbiter #(
  parameter int unsigned NUM_M     = 3,
  parameter int unsigned DEFAULT_M = 0,
  parameter int unsigned MAX_HOLD  = 8
) (
  input logic          i_hclk,
  input logic          i_hreset,
  ahb_arbiter_if.slave bus_if
);

  localparam int unsigned      CntW     = $clog2(MAX_HOLD + 1);
  localparam logic [1:0]       DefIdx   = 2'(DEFAULT_M);
  localparam logic [NUM_M-1:0] DefGrant = NUM_M'(1) << DEFAULT_M;
  localparam logic [CntW-1:0]  CntMax   = CntW'(MAX_HOLD);
  localparam logic [1:0]       TrIdle   = 2'b00;
  localparam logic [1:0]       TrBusy   = 2'b01;

  logic [NUM_M-1:0] r_grant;
  logic [1:0]       r_owner;
  logic [1:0]       r_master_d;
  logic             r_mastlock;
  logic [CntW-1:0]  r_hold_cnt;

  logic             w_locked;
  logic             w_arb_en;
  logic [1:0]       w_next;
  logic [NUM_M-1:0] w_next_grant;
  logic             w_next_lock;

  // Scanning from the farthest candidate to the nearest lets the nearest
  // requester win; the owner itself sits at distance NUM_M, i.e. last.
  function automatic logic [1:0] rr_pick(input logic [NUM_M-1:0] req, input logic [1:0] owner);
    logic [1:0]  pick;
    int unsigned idx;
    pick = DefIdx;
    for (int unsigned i = NUM_M; i >= 1; i--) begin
      idx = (32'(owner) + i) % NUM_M;
      if (req[idx]) pick = idx[1:0];
    end
    return pick;
  endfunction

  always_comb begin
    w_locked = bus_if.hlock[r_owner] & bus_if.hbusreq[r_owner];
    w_arb_en = bus_if.hready & ~w_locked & (bus_if.htrans != TrBusy) &
               (~bus_if.hbusreq[r_owner] |
                ((r_hold_cnt >= CntMax) & (bus_if.htrans == TrIdle)));
    w_next = r_owner;
    if (w_arb_en) begin
      w_next = (|bus_if.hbusreq) ? rr_pick(bus_if.hbusreq, r_owner) : DefIdx;
    end
    w_next_grant = NUM_M'(1) << w_next;
    w_next_lock  = bus_if.hlock[w_next] & bus_if.hbusreq[w_next];
  end

  always_ff @(posedge i_hclk or posedge i_hreset) begin
    if (i_hreset) begin
      r_owner    <= DefIdx;
      r_grant    <= DefGrant;
      r_master_d <= DefIdx;
      r_mastlock <= 1'b0;
      r_hold_cnt <= '0;
    end else begin
      r_owner    <= w_next;
      r_grant    <= w_next_grant;
      r_mastlock <= w_next_lock;
      if (bus_if.hready) r_master_d <= r_owner;
      if (w_next != r_owner) begin
        r_hold_cnt <= '0;
      end else if (bus_if.hready & bus_if.htrans[1] & (r_hold_cnt < CntMax)) begin
        r_hold_cnt <= r_hold_cnt + CntW'(1);
      end
    end
  end

  assign bus_if.hgrant    = r_grant;
  assign bus_if.hmaster   = r_owner;
  assign bus_if.hmaster_d = r_master_d;
  assign bus_if.hmastlock = r_mastlock;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed bench for ahb_arbiter: a cycle model of the arbitration rules checked every
// cycle, plus literal expectations for parking, round-robin, waits, lock, pre-emption, reset.
module tb_ahb_arbiter;
  localparam int N    = 3;
  localparam int DEF  = 0;
  localparam int MAXH = 8;
  localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NSEQ = 2'b10, SEQ = 2'b11;

  logic clk    = 1'b0;
  logic hreset = 1'b1;
  always #5 clk = ~clk;

  ahb_arbiter_if #(.NUM_M(N)) bus ();

  ahb_arbiter #(
    .NUM_M    (N),
    .DEFAULT_M(DEF),
    .MAX_HOLD (MAXH)
  ) dut (
    .i_hclk  (clk),
    .i_hreset(hreset),
    .bus_if  (bus)
  );

  int n_vec  = 0;
  int n_miss = 0;

  // Model state: owner index, accepted-transfer count, data-phase owner, lock flag.
  int m_own  = DEF;
  int m_cnt  = 0;
  int m_md   = DEF;
  bit m_lock = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge hreset) begin
    int  nxt;
    int  c;
    bit  owner_req;
    bit  arb;
    if (hreset) begin
      m_own  = DEF;
      m_cnt  = 0;
      m_md   = DEF;
      m_lock = 1'b0;
    end else begin
      owner_req = bus.hbusreq[m_own];
      arb = bus.hready && !(bus.hlock[m_own] && owner_req) && bus.htrans != BUSY &&
            (!owner_req || (m_cnt >= MAXH && bus.htrans == IDLE));
      nxt = m_own;
      if (arb) begin
        nxt = DEF;
        for (int k = N; k >= 1; k--) begin
          c = (m_own + k) % N;
          if (bus.hbusreq[c]) nxt = c;
        end
      end
      if (bus.hready) m_md = m_own;
      m_lock = bus.hlock[nxt] && bus.hbusreq[nxt];
      if (nxt != m_own) m_cnt = 0;
      else if (bus.hready && bus.htrans[1] && m_cnt < MAXH) m_cnt++;
      m_own = nxt;
    end
  end

  always @(negedge clk) begin
    chk("model_hgrant", 32'(bus.hgrant), 32'(1 << m_own));
    chk("model_hmaster", 32'(bus.hmaster), 32'(m_own));
    chk("model_hmaster_d", 32'(bus.hmaster_d), 32'(m_md));
    chk("model_hmastlock", 32'(bus.hmastlock), 32'(m_lock));
  end

  task automatic drv(input logic [2:0] req, input logic [2:0] lck, input logic [1:0] tr,
                     input logic rdy);
    bus.hbusreq = req;
    bus.hlock   = lck;
    bus.htrans  = tr;
    bus.hready  = rdy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.hbusreq = '0;
    bus.hlock   = '0;
    bus.htrans  = IDLE;
    bus.hready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    hreset = 1'b0;
    chk("rst_hgrant", 32'(bus.hgrant), 32'h1);
    chk("rst_hmaster_d", 32'(bus.hmaster_d), 32'h0);

    // Parking on the default master.
    repeat (5) begin
      drv(3'b000, 3'b000, IDLE, 1'b1);
      chk("park_hgrant", 32'(bus.hgrant), 32'h1);
      chk("park_hmaster_d", 32'(bus.hmaster_d), 32'h0);
    end

    // Round-robin 0 -> 1 -> 2 -> 0.
    drv(3'b111, 3'b000, IDLE, 1'b1);
    chk("rr_hold0", 32'(bus.hgrant), 32'h1);
    drv(3'b110, 3'b000, NSEQ, 1'b1);
    chk("rr_to1", 32'(bus.hgrant), 32'h2);
    drv(3'b101, 3'b000, NSEQ, 1'b1);
    chk("rr_to2", 32'(bus.hgrant), 32'h4);
    drv(3'b011, 3'b000, NSEQ, 1'b1);
    chk("rr_to0", 32'(bus.hgrant), 32'h1);

    // Wait states freeze the handover.
    drv(3'b010, 3'b000, IDLE, 1'b1);
    chk("ws_own1", 32'(bus.hgrant), 32'h2);
    drv(3'b010, 3'b000, IDLE, 1'b1);
    chk("ws_md1", 32'(bus.hmaster_d), 32'h1);
    repeat (3) begin
      drv(3'b100, 3'b000, IDLE, 1'b0);
      chk("ws_frozen", 32'(bus.hgrant), 32'h2);
    end
    drv(3'b100, 3'b000, IDLE, 1'b1);
    chk("ws_to2", 32'(bus.hgrant), 32'h4);
    chk("ws_md_old", 32'(bus.hmaster_d), 32'h1);
    drv(3'b100, 3'b000, IDLE, 1'b1);
    chk("ws_md_new", 32'(bus.hmaster_d), 32'h2);

    // Lock held by master 2 against competing requests.
    for (int i = 0; i < 20; i++) begin
      drv(3'b111, 3'b100, IDLE, 1'b1);
      chk("lock_hgrant", 32'(bus.hgrant), 32'h4);
      chk("lock_hmastlock", 32'(bus.hmastlock), 32'h1);
    end
    drv(3'b111, 3'b000, IDLE, 1'b1);
    chk("unlock_hmastlock", 32'(bus.hmastlock), 32'h0);
    chk("unlock_hgrant", 32'(bus.hgrant), 32'h4);
    drv(3'b011, 3'b000, IDLE, 1'b1);
    chk("unlock_to0", 32'(bus.hgrant), 32'h1);

    // Pre-emption only after MAX_HOLD transfers and only on IDLE.
    for (int i = 0; i < MAXH; i++) begin
      drv(3'b011, 3'b000, (i == 0) ? NSEQ : SEQ, 1'b1);
      chk("hold_no_preempt", 32'(bus.hgrant), 32'h1);
    end
    drv(3'b011, 3'b000, IDLE, 1'b1);
    chk("hold_preempt", 32'(bus.hgrant), 32'h2);

    // BUSY blocks arbitration even when the owner has released.
    drv(3'b101, 3'b000, BUSY, 1'b1);
    chk("busy_hold", 32'(bus.hgrant), 32'h2);
    drv(3'b101, 3'b000, IDLE, 1'b1);
    chk("busy_release", 32'(bus.hgrant), 32'h4);

    // Asynchronous reset in the middle of a stalled burst by master 1.
    drv(3'b010, 3'b000, IDLE, 1'b1);
    chk("rstmid_own1", 32'(bus.hgrant), 32'h2);
    bus.htrans = SEQ;
    bus.hready = 1'b0;
    #2;
    hreset = 1'b1;
    #1;
    chk("rstmid_hgrant", 32'(bus.hgrant), 32'h1);
    chk("rstmid_hmaster", 32'(bus.hmaster), 32'h0);
    chk("rstmid_hmaster_d", 32'(bus.hmaster_d), 32'h0);
    chk("rstmid_hmastlock", 32'(bus.hmastlock), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    hreset = 1'b0;

    // Mixed traffic, checked by the model alone.
    repeat (300) begin
      drv(3'($urandom), ($urandom_range(3) == 0) ? 3'($urandom) : 3'b000,
          2'($urandom), ($urandom_range(3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
